// File: rtl/radix5_pkg.sv
// Shared types for the radix-5 input loader: sample and 5-sample frame layouts.
package radix5_pkg;

    localparam int NPT    = 5;
    localparam int DW_DEF = 32;

    typedef struct packed {
        logic [DW_DEF-1:0] re;
        logic [DW_DEF-1:0] img;
    } cplx_t;

    typedef cplx_t [NPT-1:0] frame_t;

endpackage

// File: rtl/radix5_bank.sv
// One 5-slot frame register; writes the addressed slot when wr_en is high.
// Latency: written slot visible the cycle after the write. No backpressure of its own.
module radix5_bank
    import radix5_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  cplx_t      wr_dat,
    output frame_t     frame_dat
);

    frame_t frame_q;
    frame_t frame_d;

    always_comb begin
        frame_d = frame_q;
        for (int i = 0; i < NPT; i++) begin
            if (wr_en && (wr_idx == 3'(i))) begin
                frame_d[i] = wr_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_dat = frame_q;

endmodule

// File: rtl/radix5_in_loader.sv
// Packs a serial sample stream into ping-pong 5-sample frames for the radix-5 butterfly.
// Latency: out_valid rises the cycle after the 5th accept. in_ready drops only when both banks are full.
// Optional RADIX5_LAST_CHK_EN adds in_last framing checks with an err_frame pulse.
module radix5_in_loader
    import radix5_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_img,
    input  logic          in_valid,
    output logic          in_ready,
`ifdef RADIX5_LAST_CHK_EN
    input  logic          in_last,
    output logic          err_frame,
`endif
    output logic [DW-1:0] x0_re,
    output logic [DW-1:0] x1_re,
    output logic [DW-1:0] x2_re,
    output logic [DW-1:0] x3_re,
    output logic [DW-1:0] x4_re,
    output logic [DW-1:0] x0_img,
    output logic [DW-1:0] x1_img,
    output logic [DW-1:0] x2_img,
    output logic [DW-1:0] x3_img,
    output logic [DW-1:0] x4_img,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    fill_lvl
);

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] wr_cnt_q,  wr_cnt_d;
    logic [1:0] full_q,    full_d;

    logic   accept;
    logic   drain;
    logic   last_slot;
    logic   commit;
    logic   abort;
    cplx_t  wr_dat;
    frame_t bank_frame [2];
    frame_t rd_frame;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_slot = (wr_cnt_q == 3'(NPT - 1));
    assign commit    = accept && last_slot;
    assign wr_dat    = '{re: in_re, img: in_img};

`ifdef RADIX5_LAST_CHK_EN
    logic err_frame_q, err_frame_d;

    // An early in_last drops the partial frame; a missing in_last on slot 4 still commits.
    assign abort       = accept && in_last && !last_slot;
    assign err_frame_d = abort || (commit && !in_last);
    assign err_frame   = err_frame_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_frame_q <= 1'b0;
        end else begin
            err_frame_q <= err_frame_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        full_d    = full_q;
        // Drain and commit always target different banks, so both may apply together.
        if (drain) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        if (commit) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_cnt_d          = '0;
        end else if (abort) begin
            wr_cnt_d = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        radix5_bank u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (accept && (wr_bank_q == 1'(b))),
            .wr_idx    (wr_cnt_q),
            .wr_dat    (wr_dat),
            .frame_dat (bank_frame[b])
        );
    end

    assign rd_frame = rd_bank_q ? bank_frame[1] : bank_frame[0];

    assign x0_re  = rd_frame[0].re;
    assign x1_re  = rd_frame[1].re;
    assign x2_re  = rd_frame[2].re;
    assign x3_re  = rd_frame[3].re;
    assign x4_re  = rd_frame[4].re;
    assign x0_img = rd_frame[0].img;
    assign x1_img = rd_frame[1].img;
    assign x2_img = rd_frame[2].img;
    assign x3_img = rd_frame[3].img;
    assign x4_img = rd_frame[4].img;

    assign fill_lvl = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: doc/radix5_in_loader.md
Name: radix5_in_loader

Overview:
Upstream feeder for the radix-5 butterfly pipeline. It accepts a serial stream of complex samples (32-bit re/img words) under a valid/ready handshake and packs each group of 5 consecutive samples into one parallel frame x0..x4. The frame is presented to the butterfly, which consumes x3/x4 as its d/e operands. Frames are double-buffered (ping-pong), so one sample per cycle is sustained while the downstream side drains.

Parameters:
DW, 32, width of each real/imag word; the block treats the data as opaque bits and does no arithmetic.
NPT, 5, samples per frame; fixed at 5, must not be overridden.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active low
in_re  in  DW  sample real part
in_img  in  DW  sample imaginary part
in_valid  in  1  sample present
in_ready  out  1  loader can accept a sample this cycle
x0_re..x4_re  out  DW each  frame real parts; x0 is the oldest sample
x0_img..x4_img  out  DW each  frame imaginary parts
out_valid  out  1  frame on x* is complete
out_ready  in  1  downstream takes the frame this cycle
fill_lvl  out  2  number of full banks (0..2)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Storage: 2 banks x 5 slots of {re, img} registers.
- State: wr_bank (1b), wr_cnt (0..4), rd_bank (1b), full[1:0].
- Reset (rst_n=0 at a clk edge): all bank registers = 0, wr_cnt = 0, wr_bank = 0, rd_bank = 0, full = 0.
- Outputs during reset: out_valid = 0, in_ready = 1 after reset, x* = 0, fill_lvl = 0.
- Reset mid-frame discards any partial frame and any unread frames. No output follows.
- Accept: when in_valid && in_ready, the sample is written to slot wr_cnt of bank wr_bank.
  - wr_cnt < 4: wr_cnt increments.
  - wr_cnt == 4: full[wr_bank] sets, wr_bank toggles, wr_cnt returns to 0.
- in_ready = !full[wr_bank]. This is combinational from registers and does not depend on out_ready, so there is no comb path from out_ready to in_ready.
- Read side:
  - out_valid = full[rd_bank].
  - x* = slots of bank rd_bank, driven directly from registers.
  - On out_valid && out_ready: full[rd_bank] clears and rd_bank toggles.
  - x* stay stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises the cycle after the 5th sample of a frame is accepted.
- Simultaneous completion of bank A and drain of bank B in the same cycle is legal. Both updates take effect.
- Throughput: continuous in_valid=1 with out_ready=1 gives in_ready=1 every cycle and one frame every 5 cycles.
- Both banks full: in_ready = 0 and incoming samples are held off, never dropped. in_ready returns to 1 in the cycle after the first out_ready handshake.
- in_valid=0 gaps inside a frame are allowed. wr_cnt holds.
- fill_lvl = full[0] + full[1].

Optional Feature:
RADIX5_LAST_CHK_EN
- With the macro defined:
  - Adds input in_last (1b, qualified by the in handshake) and output err_frame (1b).
  - in_last accepted while wr_cnt != 4: the partial frame is discarded, wr_cnt = 0, the bank is not marked full, and err_frame pulses for 1 cycle.
  - Slot 4 accepted without in_last: the frame is still committed and err_frame pulses for 1 cycle.
  - err_frame resets to 0.
- Without the macro: neither port exists, and framing is by count only.

Decomposition:
- Package radix5_pkg:
  - localparam NPT = 5.
  - DW default.
  - Typedef cplx_t {logic [DW-1:0] re, img}.
  - Typedef frame_t = cplx_t [NPT-1:0].
- Natural sub-module: radix5_bank, one 5-slot frame register with write-enable and slot index. It is instantiated twice; the top holds the pointers and full flags.

Test Plan:
- Reset, then stream re = 1..5, img = 101..105 with out_ready=1:
  - out_valid=1 exactly 1 cycle after the 5th accept.
  - x0_re..x4_re = 1..5 and x0_img..x4_img = 101..105.
  - out_valid clears the next cycle.
- Hold out_ready=0 and stream 12 samples:
  - 10 samples are accepted.
  - in_ready=0 from the cycle after the 10th accept, and fill_lvl=2.
  - x* hold frame 1.
  - Raise out_ready for 1 cycle: in_ready=1 the next cycle and x* show frame 2.
- Stream 50 samples back-to-back with out_ready=1: in_ready stays 1 throughout, 10 frames appear in order, and none are lost or duplicated.
- Accept 3 samples, assert rst_n=0 for 1 cycle, then send 5 new samples: only the new frame is output, with its first new sample in x0.
- Randomise in_valid gaps and out_ready backpressure over 1000 samples: the scoreboard matches every frame and no handshake is violated.
- With RADIX5_LAST_CHK_EN defined, send in_last on the 3rd sample:
  - err_frame pulses once and no frame is output.
  - The next 5 samples form a correct frame.
